// File: rtl/i2c_sequencer.sv
// i2c_sequencer: runs a list of transactions on a downstream transmitter.
// Each transaction is launched with start_trans, confirmed by the transmitter
// leaving idle, and finished when it returns to idle. Between transactions the
// sequencer waits a programmable number of bus clock-high ticks. The sequence
// either stops after num_trans transactions or, in loop mode, repeats forever.
// It can be cut short by abort at any point.
//
// Handshake with the transmitter: start_trans is a one-cycle request. The request
// counts as accepted only once idle is seen low. The transaction counts as
// finished once idle is seen high again.
module i2c_sequencer #(
    parameter int IDX_W = 6,
    parameter int GAP_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             idle,
    input  logic             cl_high,
    input  logic [IDX_W-1:0] num_trans,
    input  logic [GAP_W-1:0] gap_highs,
    input  logic             loop_mode,
    output logic             start_trans,
    output logic             inc_trans,
    output logic [IDX_W-1:0] trans_index,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_START  = 7'b0000010,
        S_ACK    = 7'b0000100,
        S_TRANS  = 7'b0001000,
        S_UPDATE = 7'b0010000,
        S_WAIT   = 7'b0100000,
        S_DONE   = 7'b1000000
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    // state is the observable FSM state for external checkers
    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] num_lat;
    logic [GAP_W-1:0] gap_lat;
    logic             loop_lat;
    logic [GAP_W-1:0] gap_cnt;
    logic             pend;

    // decoded control strobes from the next-state logic
    logic             accept;
    logic             load_seq;
    logic             ab_set;
    logic             pend_clr;
    logic             idx_inc;
    logic             idx_wrap;
    logic             last;

    assign last = (trans_index == (num_lat - IDX_ONE));

    // outputs are pure decodes of the current state
    assign start_trans = (state == S_START);
    assign inc_trans   = (state == S_UPDATE);
    assign done        = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and control strobes; abort beats the gap match in WAIT
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_seq   = 1'b0;
        ab_set     = 1'b0;
        pend_clr   = 1'b0;
        idx_inc    = 1'b0;
        idx_wrap   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (num_trans != '0) begin
                        load_seq   = 1'b1;
                        state_next = S_START;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_START: begin
                if (abort) begin
                    ab_set     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!idle) state_next = S_TRANS;
            end
            S_TRANS: begin
                if (idle) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                if (pend) begin
                    ab_set     = 1'b1;
                    pend_clr   = 1'b1;
                    state_next = S_DONE;
                end else if (!last) begin
                    idx_inc    = 1'b1;
                    state_next = S_WAIT;
                end else if (loop_lat) begin
                    idx_wrap   = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    ab_set     = 1'b1;
                    state_next = S_DONE;
                end else if (gap_cnt == gap_lat) begin
                    state_next = S_START;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // sequence parameters captured on an accepted non-empty start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_lat  <= '0;
            gap_lat  <= '0;
            loop_lat <= 1'b0;
        end else if (load_seq) begin
            num_lat  <= num_trans;
            gap_lat  <= gap_highs;
            loop_lat <= loop_mode;
        end
    end

    // transaction pointer, modulo 2^IDX_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trans_index <= '0;
        end else if (load_seq || idx_wrap) begin
            trans_index <= '0;
        end else if (idx_inc) begin
            trans_index <= trans_index + IDX_ONE;
        end
    end

    // gap counter counts clock-high ticks only while staying in WAIT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gap_cnt <= '0;
        end else if (state == S_WAIT && state_next == S_WAIT) begin
            if (cl_high) gap_cnt <= gap_cnt + GAP_ONE;
        end else begin
            gap_cnt <= '0;
        end
    end

    // abort seen mid-transaction is deferred until the transaction finishes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (accept || pend_clr) begin
            pend <= 1'b0;
        end else if (abort && (state == S_ACK || state == S_TRANS)) begin
            pend <= 1'b1;
        end
    end

    // sticky aborted flag, cleared by the next accepted start
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aborted <= 1'b0;
        end else if (ab_set) begin
            aborted <= 1'b1;
        end else if (accept) begin
            aborted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_sequencer.sv
// Bench for i2c_sequencer: directed scenarios, a transmitter model, and a
// scoreboard of expected output events checked by an independent monitor.
// Event word: {kind[1:0], index[5:0], aborted}; index is zero for done events.
module tb_i2c_sequencer;

    localparam int IDX_W = 6;
    localparam int GAP_W = 6;
    localparam int W     = 9;

    localparam logic [1:0] EV_START = 2'd1;
    localparam logic [1:0] EV_INC   = 2'd2;
    localparam logic [1:0] EV_DONE  = 2'd3;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             idle;
    logic             cl_high;
    logic [IDX_W-1:0] num_trans;
    logic [GAP_W-1:0] gap_highs;
    logic             loop_mode;
    logic             start_trans;
    logic             inc_trans;
    logic [IDX_W-1:0] trans_index;
    logic             busy;
    logic             done;
    logic             aborted;

    logic [W-1:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           last_inc_cyc = 0;
    int           gap_meas = 0;
    int           done_cnt = 0;
    int           busy_cyc = 0;
    bit           cl_en    = 1'b1;

    i2c_sequencer #(.IDX_W(IDX_W), .GAP_W(GAP_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .idle        (idle),
        .cl_high     (cl_high),
        .num_trans   (num_trans),
        .gap_highs   (gap_highs),
        .loop_mode   (loop_mode),
        .start_trans (start_trans),
        .inc_trans   (inc_trans),
        .trans_index (trans_index),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [W-1:0] act);
        logic [W-1:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected event %0h with empty queue", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                failures++;
                $display("FAIL %s: got event %0h expected %0h", name, act, exp);
            end
        end
    endtask

    task automatic push(input logic [1:0] kind, input int idx, input logic ab);
        logic [IDX_W-1:0] i;
        i = IDX_W'(idx);
        exp_q.push_back({kind, i, ab});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (busy) busy_cyc++;
            if (start_trans) begin
                gap_meas = cyc - last_inc_cyc;
                sb_check("start_ev", {EV_START, trans_index, aborted});
            end
            if (inc_trans) begin
                last_inc_cyc = cyc;
                sb_check("inc_ev", {EV_INC, trans_index, aborted});
            end
            if (done) begin
                done_cnt++;
                sb_check("done_ev", {EV_DONE, 6'd0, aborted});
            end
        end
    end

    // ---------------- transmitter model ----------------
    initial begin
        idle = 1'b1;
        forever begin
            @(negedge clock);
            if (start_trans) begin
                @(posedge clock); #1 idle = 1'b0;
                repeat (10) @(posedge clock);
                #1 idle = 1'b1;
            end
        end
    end

    // ---------------- bus clock-high ticks, one every 4 cycles ----------------
    initial begin
        cl_high = 1'b0;
        forever begin
            @(posedge clock); #1;
            cl_high = cl_en && (cyc % 4 == 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input int n, input int gap, input logic lp);
        @(posedge clock); #1;
        start     = 1'b1;
        num_trans = IDX_W'(n);
        gap_highs = GAP_W'(gap);
        loop_mode = lp;
        @(posedge clock); #1;
        start     = 1'b0;
    endtask

    task automatic wait_start(input int idx, input int nth, input string name);
        int seen;
        bit ok;
        seen = 0;
        ok   = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (start_trans && trans_index == IDX_W'(idx)) begin
                seen++;
                if (seen == nth) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: start_trans idx %0d #%0d not seen, got %0d", name, idx, nth, seen);
        end
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: done got 0 expected 1 within budget", name);
        end
        @(negedge clock);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic pulse_abort_after(input int k);
        repeat (k) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        num_trans = '0;
        gap_highs = '0;
        loop_mode = 1'b0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_start_trans", 32'(start_trans), 0);
        chk("rst_inc_trans",   32'(inc_trans),   0);
        chk("rst_busy",        32'(busy),        0);
        chk("rst_done",        32'(done),        0);
        chk("rst_aborted",     32'(aborted),     0);
        chk("rst_index",       32'(trans_index), 0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);

        // three transactions, gap of 2 ticks; a stray start mid-sequence is ignored
        done_cnt = 0;
        for (int t = 0; t < 3; t++) begin
            push(EV_START, t, 1'b0);
            push(EV_INC, t, 1'b0);
        end
        push(EV_DONE, 0, 1'b0);
        issue_start(3, 2, 1'b0);
        wait_start(0, 1, "seq3_first_start");
        #1 start = 1'b1; num_trans = 6'd7; loop_mode = 1'b1;
        @(posedge clock); #1 start = 1'b0; loop_mode = 1'b0;
        wait_done("seq3");
        chk("seq3_aborted", 32'(aborted), 0);
        chk("seq3_done_cnt", done_cnt, 1);

        // empty sequence: done only, busy for a single cycle
        done_cnt = 0;
        busy_cyc = 0;
        push(EV_DONE, 0, 1'b0);
        issue_start(0, 0, 1'b0);
        wait_done("empty");
        chk("empty_busy_cycles", busy_cyc, 1);
        chk("empty_done_cnt", done_cnt, 1);

        // loop mode over two transactions; stop with abort during the fifth
        done_cnt = 0;
        for (int t = 0; t < 5; t++) begin
            push(EV_START, t % 2, 1'b0);
            push(EV_INC, t % 2, 1'b0);
        end
        push(EV_DONE, 0, 1'b1);
        issue_start(2, 1, 1'b1);
        wait_start(0, 3, "loop_fifth_start");
        chk("loop_no_done_yet", done_cnt, 0);
        pulse_abort_after(4);
        wait_done("loop");
        chk("loop_aborted", 32'(aborted), 1);

        // zero gap with no clock-high ticks: one WAIT cycle between inc and start
        cl_en = 1'b0;
        push(EV_START, 0, 1'b0);
        push(EV_INC, 0, 1'b0);
        push(EV_START, 1, 1'b0);
        push(EV_INC, 1, 1'b0);
        push(EV_DONE, 0, 1'b0);
        issue_start(2, 0, 1'b0);
        wait_done("gap0");
        chk("gap0_inc_to_start", gap_meas, 2);
        cl_en = 1'b1;

        // abort during transaction 1 of 4: it completes, then the sequence ends
        push(EV_START, 0, 1'b0);
        push(EV_INC, 0, 1'b0);
        push(EV_START, 1, 1'b0);
        push(EV_INC, 1, 1'b0);
        push(EV_DONE, 0, 1'b1);
        issue_start(4, 1, 1'b0);
        wait_start(1, 1, "abort_t1_start");
        pulse_abort_after(4);
        wait_done("abort_t1");
        chk("abort_t1_aborted", 32'(aborted), 1);
        repeat (30) @(negedge clock);
        chk("abort_t1_no_more_events", exp_q.size(), 0);

        // asynchronous reset in the middle of transaction 1
        done_cnt = 0;
        push(EV_START, 0, 1'b0);
        push(EV_INC, 0, 1'b0);
        push(EV_START, 1, 1'b0);
        issue_start(3, 1, 1'b0);
        wait_start(1, 1, "rst_mid_start");
        repeat (4) @(posedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("amid_busy",        32'(busy),        0);
        chk("amid_start_trans", 32'(start_trans), 0);
        chk("amid_inc_trans",   32'(inc_trans),   0);
        chk("amid_done",        32'(done),        0);
        chk("amid_aborted",     32'(aborted),     0);
        chk("amid_index",       32'(trans_index), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (20) @(negedge clock);
        chk("amid_no_done", done_cnt, 0);
        chk("amid_queue_empty", exp_q.size(), 0);
        push(EV_START, 0, 1'b0);
        push(EV_INC, 0, 1'b0);
        push(EV_DONE, 0, 1'b0);
        issue_start(1, 0, 1'b0);
        wait_done("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
